// File: rtl/delay_ctrl.sv
// delay_ctrl: runtime-programmable delay line with valid/ready config port.
// Optional build macro DELAY_STATS_EN adds reconf_cnt (reconfiguration count).
//
// Ports:
//   clk        clock, all logic on posedge
//   rst        synchronous active-high reset
//   sig_in     signal to delay
//   cfg_delay  requested delay in cycles
//   cfg_valid  config request valid
//   cfg_ready  controller can accept config (RUN)
//   sig_out    delayed signal, forced 0 while settling
//   sig_valid  sig_out coherent at cur_delay
//   cur_delay  active delay value
//   err_range  one-cycle pulse on out-of-range request
//   reconf_cnt value-changing reconfigurations, saturating
//              (DELAY_STATS_EN only)
module delay_ctrl #(
   parameter int MAX_DELAY     = 16,
   parameter int DELAY_W       = 5,
   parameter int DEFAULT_DELAY = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               sig_in,
   input  logic [DELAY_W-1:0] cfg_delay,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   output logic               sig_out,
   output logic               sig_valid,
   output logic [DELAY_W-1:0] cur_delay,
   output logic               err_range
`ifdef DELAY_STATS_EN
   ,
   output logic [7:0]         reconf_cnt
`endif
);

   typedef enum logic {
      RUN    = 1'b0,
      SETTLE = 1'b1
   } state_t;

   state_t               state;
   logic [MAX_DELAY-1:0] sr;
   logic [DELAY_W-1:0]   cnt;
   logic                 tap;
   logic                 bad_req;

   // Full-width compare: no truncation of cfg_delay.
   assign bad_req = (cfg_delay == '0) ||
                    (cfg_delay > DELAY_W'(MAX_DELAY));

   // Tap select by compare instead of indexing, so the
   // DELAY_W-bit delay never indexes past the register.
   always_comb begin
      tap = 1'b0;
      for (int i = 0; i < MAX_DELAY; i++) begin
         if (cur_delay == DELAY_W'(i + 1))
            tap = sr[i];
      end
   end

   assign cfg_ready = (state == RUN);
   assign sig_valid = (state == RUN);
   assign sig_out   = (state == RUN) ? tap : 1'b0;

   always_ff @(posedge clk) begin
      if (rst) begin
         sr        <= '0;
         state     <= SETTLE;
         cur_delay <= DELAY_W'(DEFAULT_DELAY);
         cnt       <= DELAY_W'(DEFAULT_DELAY);
         err_range <= 1'b0;
`ifdef DELAY_STATS_EN
         reconf_cnt <= 8'd0;
`endif
      end else begin
         sr        <= {sr[MAX_DELAY-2:0], sig_in};
         err_range <= 1'b0;
         unique case (state)
            RUN: begin
               if (cfg_valid) begin
                  if (bad_req) begin
                     err_range <= 1'b1;
                  end else if (cfg_delay != cur_delay) begin
                     cur_delay <= cfg_delay;
                     cnt       <= cfg_delay;
                     state     <= SETTLE;
`ifdef DELAY_STATS_EN
                     if (reconf_cnt != 8'hff)
                        reconf_cnt <= reconf_cnt + 8'd1;
`endif
                  end
               end
            end
            SETTLE: begin
               // Settle spans cur_delay cycles so the tap
               // only shows samples taken after the change.
               cnt <= cnt - DELAY_W'(1);
               if (cnt == DELAY_W'(1))
                  state <= RUN;
            end
            default: state <= SETTLE;
         endcase
      end
   end

endmodule

// File: tb/tb_delay_ctrl.sv
// tb_delay_ctrl: directed self-checking bench for delay_ctrl.
// Expected values are hand-derived from the delay/settle rules.
module tb_delay_ctrl;

   localparam int DW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          sig_in;
   logic [DW-1:0] cfg_delay;
   logic          cfg_valid;
   logic          cfg_ready;
   logic          sig_out;
   logic          sig_valid;
   logic [DW-1:0] cur_delay;
   logic          err_range;
`ifdef DELAY_STATS_EN
   logic [7:0]    reconf_cnt;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   delay_ctrl #(
      .MAX_DELAY     (16),
      .DELAY_W       (DW),
      .DEFAULT_DELAY (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .sig_in    (sig_in),
      .cfg_delay (cfg_delay),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .sig_out   (sig_out),
      .sig_valid (sig_valid),
      .cur_delay (cur_delay),
      .err_range (err_range)
`ifdef DELAY_STATS_EN
      ,
      .reconf_cnt (reconf_cnt)
`endif
   );

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h t=%0t",
                  tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One-cycle pulse on sig_in; sampled at edge 1,
   // must appear on sig_out only after edge d.
   task automatic pulse_check(input int d);
      sig_in = 1'b1;
      tick();
      sig_in = 1'b0;
      for (int j = 1; j <= d + 1; j++) begin
         chk("pulse", sig_out, (j == d));
         chk("pulse_vld", sig_valid, 1);
         if (j <= d) tick();
      end
   endtask

   // Accept a value-changing request, then expect
   // exactly d settle cycles with blanked output.
   task automatic change_to(input int d);
      cfg_delay = DW'(d);
      cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      chk("chg_cur", cur_delay, d);
      for (int i = 0; i < d; i++) begin
         chk("settle_vld", sig_valid, 0);
         chk("settle_out", sig_out, 0);
         tick();
      end
      chk("run_vld", sig_valid, 1);
      chk("run_rdy", cfg_ready, 1);
   endtask

   task automatic bad_req(input int v);
      cfg_delay = DW'(v);
      cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      chk("err_pulse", err_range, 1);
      chk("err_cur", cur_delay, 5);
      chk("err_vld", sig_valid, 1);
      tick();
      chk("err_clr", err_range, 0);
      chk("err_vld2", sig_valid, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      sig_in    = 1'b0;
      cfg_delay = '0;
      cfg_valid = 1'b0;
      tick();
      tick();
      chk("rst_vld", sig_valid, 0);
      chk("rst_rdy", cfg_ready, 0);
      chk("rst_out", sig_out, 0);
      chk("rst_cur", cur_delay, 2);
      chk("rst_err", err_range, 0);
`ifdef DELAY_STATS_EN
      chk("rst_cnt", reconf_cnt, 0);
`endif
      rst = 1'b0;

      // Two settle cycles after reset release.
      tick();
      chk("rel_vld1", sig_valid, 0);
      chk("rel_rdy1", cfg_ready, 0);
      tick();
      chk("rel_vld2", sig_valid, 1);
      chk("rel_rdy2", cfg_ready, 1);
      pulse_check(2);

      // Change to 5 with sig_in high: output blanked
      // during settle, then coherent 1 from first settle sample.
      sig_in = 1'b1;
      change_to(5);
      chk("coh_out", sig_out, 1);
      sig_in = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("flush_out", sig_out, 0);
      pulse_check(5);
`ifdef DELAY_STATS_EN
      chk("cnt_one", reconf_cnt, 1);
`endif

      // Out-of-range requests.
      bad_req(0);
      bad_req(17);
      bad_req(31);

      // Same-value request: consumed, no disruption.
      cfg_delay = DW'(5);
      cfg_valid = 1'b1;
      sig_in    = 1'b1;
      tick();
      cfg_valid = 1'b0;
      sig_in    = 1'b0;
      chk("same_vld", sig_valid, 1);
      chk("same_rdy", cfg_ready, 1);
      chk("same_err", err_range, 0);
      chk("same_cur", cur_delay, 5);
      for (int j = 2; j <= 6; j++) begin
         tick();
         chk("same_pulse", sig_out, (j == 5));
         chk("same_vld2", sig_valid, 1);
      end
`ifdef DELAY_STATS_EN
      chk("cnt_same", reconf_cnt, 1);
`endif

      // Change to 3, hold request for 8 through settle.
      cfg_delay = DW'(3);
      cfg_valid = 1'b1;
      tick();
      cfg_delay = DW'(8);
      for (int i = 0; i < 3; i++) begin
         chk("hold_rdy", cfg_ready, 0);
         chk("hold_cur", cur_delay, 3);
         chk("hold_err", err_range, 0);
         tick();
      end
      chk("hold_run", cfg_ready, 1);
      chk("hold_cur3", cur_delay, 3);
      tick();
      cfg_valid = 1'b0;
      chk("acc8_cur", cur_delay, 8);
      for (int i = 0; i < 8; i++) begin
         chk("s8_vld", sig_valid, 0);
         tick();
      end
      chk("s8_run", sig_valid, 1);
      pulse_check(8);

      // Boundaries: delay 1 and MAX_DELAY.
      change_to(1);
      pulse_check(1);
      change_to(16);
      pulse_check(16);

      // Reset on settle cycle 2 of a change to 10.
      sig_in    = 1'b1;
      cfg_delay = DW'(10);
      cfg_valid = 1'b1;
      tick();
      chk("r10_cur", cur_delay, 10);
      tick();
      chk("r10_vld", sig_valid, 0);
      rst    = 1'b1;
      sig_in = 1'b0;
      tick();
      rst       = 1'b0;
      cfg_valid = 1'b0;
      chk("r10_cur2", cur_delay, 2);
      chk("r10_vld2", sig_valid, 0);
      chk("r10_out", sig_out, 0);
`ifdef DELAY_STATS_EN
      chk("r10_cnt", reconf_cnt, 0);
`endif
      tick();
      chk("r10_s1", sig_valid, 0);
      tick();
      chk("r10_s2", sig_valid, 1);
      chk("r10_zero", sig_out, 0);
      change_to(4);
`ifdef DELAY_STATS_EN
      chk("cnt_after", reconf_cnt, 1);
`endif
      pulse_check(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
